graph_loader: RTL and testbench
===============================

GRAPH_LOADER -- requirements
Module: graph_loader

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port in_valid  input  1  high while an edge pair is presented on source/destination.
REQ-004 SHALL have port source  input  4  station index of the edge's first end (0..15).
REQ-005 SHALL have port destination  input  4  station index of the edge's second end (0..15).
REQ-006 SHALL have port out_ready  input  1  downstream cost engine accepts the current row.
REQ-007 SHALL have port row_valid  output  1  row_idx/row_data hold a valid adjacency row.
REQ-008 SHALL have port row_idx  output  4  station index of the presented row.
REQ-009 SHALL have port row_data  output  16  bit j set = edge between row_idx and station j.
REQ-010 SHALL have port edge_cnt  output  7  number of distinct undirected non-self edges loaded (max 120).
REQ-011 SHALL have port graph_done  output  1  one-cycle pulse after the last row is accepted.
REQ-012 SHALL have port busy  output  1  high in LOAD and EMIT states.

Function
REQ-013 SHALL implement states IDLE, LOAD, EMIT, DONE.
REQ-014 IDLE -> LOAD SHALL occur on in_valid=1; the edge present in that cycle SHALL be stored.
REQ-015 In LOAD, each cycle with in_valid=1 SHALL set adj[s][d] and adj[d][s] (undirected).
REQ-016 Self-loops (source==destination) SHALL be ignored: no matrix write, no count change.
REQ-017 edge_cnt SHALL increment only when adj[s][d] was 0 before the write; duplicates and reversed duplicates SHALL not count.
REQ-018 A pair written in cycle N SHALL be visible to the duplicate check in cycle N+1 (back-to-back duplicates counted once).
REQ-019 LOAD -> EMIT SHALL occur in the first cycle with in_valid=0; row_valid SHALL rise the next cycle with row_idx=0.
REQ-020 In EMIT, row_valid SHALL stay high and row_idx/row_data SHALL be stable until out_ready=1.
REQ-021 On row_valid&&out_ready, row_idx SHALL advance by 1 next cycle; the handshake on row 15 SHALL go to DONE with row_valid=0.
REQ-022 out_ready asserted without row_valid SHALL have no effect.
REQ-023 DONE SHALL last exactly one cycle, assert graph_done, clear the matrix, go to IDLE; edge_cnt SHALL hold until the next IDLE -> LOAD transition, where it SHALL restart from 0 or 1.
REQ-024 in_valid asserted during EMIT or DONE SHALL be ignored (no write, no state change).
REQ-025 Minimum latency, last in_valid cycle to row 15 accepted with out_ready tied high: 17 cycles.
REQ-026 A load with zero non-self edges SHALL still emit 16 all-zero rows.

Reset
REQ-027 With rst_n=0 at a clock edge, state SHALL be IDLE and row_valid, row_idx, row_data, edge_cnt, graph_done and busy SHALL all be 0 from the next edge.
REQ-028 Reset SHALL clear the whole 16x16 matrix.
REQ-029 Reset asserted mid-LOAD or mid-EMIT SHALL abort the operation with no graph_done pulse.
REQ-030 After reset release, in_valid low SHALL keep the block in IDLE with all outputs 0.

Structure
REQ-031 A shared package SHALL hold the state enum, NUM_STATION=16, STATION_W=4 and EDGE_CNT_W=7.
REQ-032 The matrix with its write/duplicate-check logic SHALL be one sub-module, adj_matrix, with two symmetric write ports and one row-read port.
REQ-033 The FSM, row counter and edge counter SHALL stay in graph_loader.

Verification
REQ-034 Edges (0,1),(1,2),(2,15), out_ready=1 -> edge_cnt=3; row0=0x0002, row1=0x0005, row2=0x8002, row15=0x0004; graph_done 17 cycles after the last in_valid cycle.
REQ-035 Edges (3,4),(4,3),(3,4),(5,5) -> edge_cnt=1; row3=0x0010, row4=0x0008, row5=0x0000.
REQ-036 Row 0 presented, out_ready low for 5 cycles then high -> row_idx and row_data stable for all 6 cycles, then row_idx=1.
REQ-037 in_valid pulsed during EMIT with (7,8) -> row7=0x0000 and edge_cnt unchanged.
REQ-038 rst_n=0 asserted while row_idx=6 -> next cycle all outputs 0; a following load of (0,1) gives edge_cnt=1 with no residue from the earlier graph.
REQ-039 Two graphs back-to-back, the second starting the cycle after graph_done -> second graph's rows contain only its own edges.

Source files
------------

// File: rtl/graph_loader_pkg.sv
// Shared types and sizing for the graph loader: FSM state encoding and
// station/edge-count widths used by the top, the matrix and the interface.
package graph_loader_pkg;

  localparam int NUM_STATION = 16;
  localparam int STATION_W   = 4;
  localparam int EDGE_CNT_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/graph_loader_if.sv
// Edge-input and row-output bundle between the graph loader and its
// producer/consumer; slave is the loader side, master the driving side.
interface graph_loader_if;
  import graph_loader_pkg::*;

  logic                   in_valid;
  logic [STATION_W-1:0]   source;
  logic [STATION_W-1:0]   destination;
  logic                   out_ready;
  logic                   row_valid;
  logic [STATION_W-1:0]   row_idx;
  logic [NUM_STATION-1:0] row_data;
  logic [EDGE_CNT_W-1:0]  edge_cnt;
  logic                   graph_done;
  logic                   busy;

  modport slave (
    input  in_valid, source, destination, out_ready,
    output row_valid, row_idx, row_data, edge_cnt, graph_done, busy
  );

  modport master (
    output in_valid, source, destination, out_ready,
    input  row_valid, row_idx, row_data, edge_cnt, graph_done, busy
  );

endinterface

// File: rtl/graph_loader_adj_matrix.sv
// 16x16 adjacency bit matrix with two write ports (one per direction of an
// undirected edge), a duplicate-check tap on port A and one row-read port.
module adj_matrix
  import graph_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   wrEnA_i,
  input  logic [STATION_W-1:0]   rowA_i,
  input  logic [STATION_W-1:0]   colA_i,
  input  logic                   wrEnB_i,
  input  logic [STATION_W-1:0]   rowB_i,
  input  logic [STATION_W-1:0]   colB_i,
  output logic                   hit_o,
  input  logic [STATION_W-1:0]   rdIdx_i,
  output logic [NUM_STATION-1:0] rdData_o
);

  logic [NUM_STATION-1:0] mat_q [NUM_STATION];

  // Writes land at the edge, so a pair written this cycle is seen by hit_o next cycle
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      for (int i = 0; i < NUM_STATION; i++) begin
        mat_q[i] <= '0;
      end
    end else begin
      if (wrEnA_i) mat_q[rowA_i][colA_i] <= 1'b1;
      if (wrEnB_i) mat_q[rowB_i][colB_i] <= 1'b1;
    end
  end

  assign hit_o    = mat_q[rowA_i][colA_i];
  assign rdData_o = mat_q[rdIdx_i];

endmodule

// File: rtl/graph_loader.sv
// Collects undirected edges into an adjacency matrix, then streams its 16
// rows to a downstream engine under a valid/ready handshake.
module graph_loader
  import graph_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  graph_loader_if.slave  bus
);

  state_t                 state_q;
  logic                   rowValid_q;
  logic [STATION_W-1:0]   rowIdx_q;
  logic [NUM_STATION-1:0] rowData_q;
  logic [EDGE_CNT_W-1:0]  edgeCnt_q;
  logic                   graphDone_q;
  logic                   busy_q;

  logic                   wrEn;
  logic                   hit;
  logic                   clr;
  logic                   isNew;
  logic [STATION_W-1:0]   rdIdx;
  logic [NUM_STATION-1:0] rdData;

  // The read port is pointed at the row that will be presented next
  always_comb begin
    wrEn  = bus.in_valid && (bus.source != bus.destination) &&
            (state_q == ST_IDLE || state_q == ST_LOAD);
    isNew = wrEn && !hit;
    clr   = (state_q == ST_DONE);
    rdIdx = (state_q == ST_EMIT) ? rowIdx_q + STATION_W'(1) : '0;
  end

  adj_matrix uMatrix (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (clr),
    .wrEnA_i  (wrEn),
    .rowA_i   (bus.source),
    .colA_i   (bus.destination),
    .wrEnB_i  (wrEn),
    .rowB_i   (bus.destination),
    .colB_i   (bus.source),
    .hit_o    (hit),
    .rdIdx_i  (rdIdx),
    .rdData_o (rdData)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rowValid_q  <= 1'b0;
      rowIdx_q    <= '0;
      rowData_q   <= '0;
      edgeCnt_q   <= '0;
      graphDone_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      graphDone_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q   <= ST_LOAD;
            busy_q    <= 1'b1;
            edgeCnt_q <= isNew ? EDGE_CNT_W'(1) : '0;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            if (isNew) edgeCnt_q <= edgeCnt_q + EDGE_CNT_W'(1);
          end else begin
            state_q    <= ST_EMIT;
            rowValid_q <= 1'b1;
            rowIdx_q   <= '0;
            rowData_q  <= rdData;
          end
        end
        ST_EMIT: begin
          if (bus.out_ready) begin
            if (rowIdx_q == STATION_W'(NUM_STATION - 1)) begin
              state_q     <= ST_DONE;
              rowValid_q  <= 1'b0;
              rowIdx_q    <= '0;
              rowData_q   <= '0;
              busy_q      <= 1'b0;
              graphDone_q <= 1'b1;
            end else begin
              rowIdx_q  <= rowIdx_q + STATION_W'(1);
              rowData_q <= rdData;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.row_valid  = rowValid_q;
  assign bus.row_idx    = rowIdx_q;
  assign bus.row_data   = rowData_q;
  assign bus.edge_cnt   = edgeCnt_q;
  assign bus.graph_done = graphDone_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_graph_loader.sv
// Self-checking bench for graph_loader: table-driven graphs plus stall,
// EMIT-time input, mid-emit reset and back-to-back corner sequences.
module tb_graph_loader;
  import graph_loader_pkg::*;

  typedef struct {
    int          n;
    logic [3:0]  s [4];
    logic [3:0]  d [4];
    logic [6:0]  expCnt;
    logic [3:0]  rowSel [4];
    logic [15:0] rowExp [4];
  } vec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } row_t;

  logic clk = 1'b0;
  logic rst_n;
  graph_loader_if bus ();

  graph_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          failures = 0;
  int          lastSample;
  vec_t        vecs [4];
  row_t        sbQ [$];
  logic [3:0]  edS [$];
  logic [3:0]  edD [$];
  logic [15:0] modelRow [16];
  logic [15:0] gotRow [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    checkOutput(name, {bus.row_valid, bus.row_idx, bus.row_data, bus.edge_cnt,
                       bus.graph_done, bus.busy}, 32'h0);
  endtask

  task automatic setEdges(input int n, input logic [3:0] s [4], input logic [3:0] d [4]);
    edS.delete();
    edD.delete();
    for (int i = 0; i < n; i++) begin
      edS.push_back(s[i]);
      edD.push_back(d[i]);
    end
  endtask

  // Drives the edge list, builds the expected rows and queues them
  task automatic applyStimulus();
    for (int i = 0; i < 16; i++) modelRow[i] = '0;
    for (int i = 0; i < edS.size(); i++) begin
      @(negedge clk);
      bus.in_valid    = 1'b1;
      bus.source      = edS[i];
      bus.destination = edD[i];
      if (edS[i] != edD[i]) begin
        modelRow[edS[i]][edD[i]] = 1'b1;
        modelRow[edD[i]][edS[i]] = 1'b1;
      end
    end
    lastSample = cyc + 1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.source      = '0;
    bus.destination = '0;
    for (int i = 0; i < 16; i++) sbQ.push_back('{4'(i), modelRow[i]});
  endtask

  // Consumes rows; optional stall on row 0, in_valid pulse, or reset at a row
  task automatic drainRows(input int stall, input int pulseAt, input int abortAt,
                           input logic [6:0] expCnt);
    int          waited = 0;
    int          accepted = 0;
    int          stallLeft = stall;
    bit          done = 0;
    bit          aborted = 0;
    bit          held = 0;
    logic [3:0]  holdIdx;
    logic [15:0] holdData;
    row_t        e;
    for (int i = 0; i < 16; i++) gotRow[i] = 16'hFFFF;
    bus.out_ready = 1'b1;
    while (!done && !aborted && waited < 300) begin
      @(negedge clk);
      waited++;
      bus.in_valid = 1'b0;
      if (bus.graph_done) begin
        done = 1;
        checkOutput("done_latency", cyc - lastSample, 17 + stall);
        checkOutput("done_outputs", {bus.row_valid, bus.busy}, 32'h0);
        checkOutput("cnt_hold", bus.edge_cnt, expCnt);
      end else if (bus.row_valid) begin
        if (abortAt >= 0 && bus.row_idx == 4'(abortAt)) begin
          rst_n   = 1'b0;
          aborted = 1;
        end else begin
          if (pulseAt >= 0 && accepted == pulseAt) begin
            bus.in_valid    = 1'b1;
            bus.source      = 4'd7;
            bus.destination = 4'd8;
          end
          if (stallLeft > 0) begin
            if (!held) begin
              holdIdx  = bus.row_idx;
              holdData = bus.row_data;
              held     = 1;
            end else begin
              checkOutput("stall_stable", {bus.row_idx, bus.row_data}, {holdIdx, holdData});
            end
            stallLeft--;
            bus.out_ready = 1'b0;
          end else begin
            if (held) begin
              checkOutput("stall_stable", {bus.row_idx, bus.row_data}, {holdIdx, holdData});
              held = 0;
            end
            bus.out_ready = 1'b1;
            if (accepted == 0) checkOutput("edge_cnt", bus.edge_cnt, expCnt);
            if (sbQ.size() == 0) begin
              checkOutput("unexpected_row", bus.row_idx, 32'hFFFF);
            end else begin
              e = sbQ.pop_front();
              checkOutput($sformatf("row%0d", e.idx), {bus.row_idx, bus.row_data}, {e.idx, e.data});
            end
            gotRow[bus.row_idx] = bus.row_data;
            accepted++;
          end
        end
      end
    end
    if (!done && !aborted) checkOutput("drain_timeout", 32'h0, 32'h1);
    if (done) begin
      checkOutput("rows_accepted", accepted, 16);
      checkOutput("sb_empty", sbQ.size(), 0);
    end
  endtask

  initial begin
    logic [3:0] s [4];
    logic [3:0] d [4];

    vecs[0] = '{3, '{4'd0, 4'd1, 4'd2, 4'd0}, '{4'd1, 4'd2, 4'd15, 4'd0}, 7'd3,
                '{4'd0, 4'd1, 4'd2, 4'd15}, '{16'h0002, 16'h0005, 16'h8002, 16'h0004}};
    vecs[1] = '{4, '{4'd3, 4'd4, 4'd3, 4'd5}, '{4'd4, 4'd3, 4'd4, 4'd5}, 7'd1,
                '{4'd3, 4'd4, 4'd5, 4'd0}, '{16'h0010, 16'h0008, 16'h0000, 16'h0000}};
    vecs[2] = '{1, '{4'd5, 4'd0, 4'd0, 4'd0}, '{4'd5, 4'd0, 4'd0, 4'd0}, 7'd0,
                '{4'd0, 4'd5, 4'd15, 4'd7}, '{16'h0000, 16'h0000, 16'h0000, 16'h0000}};
    vecs[3] = '{4, '{4'd15, 4'd0, 4'd8, 4'd9}, '{4'd0, 4'd15, 4'd9, 4'd10}, 7'd3,
                '{4'd0, 4'd15, 4'd9, 4'd8}, '{16'h8000, 16'h0001, 16'h0500, 16'h0200}};

    bus.in_valid    = 1'b0;
    bus.source      = '0;
    bus.destination = '0;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;
    repeat (3) @(negedge clk);
    checkIdle("reset_state");
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkIdle("idle_hold");
    end

    // Table graphs run back to back: each starts the cycle after graph_done
    for (int v = 0; v < 4; v++) begin
      setEdges(vecs[v].n, vecs[v].s, vecs[v].d);
      applyStimulus();
      drainRows(0, -1, -1, vecs[v].expCnt);
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("vec%0d_row%0d", v, vecs[v].rowSel[k]),
                    gotRow[vecs[v].rowSel[k]], vecs[v].rowExp[k]);
      end
    end

    s = '{4'd0, 4'd0, 4'd0, 4'd0};
    d = '{4'd1, 4'd0, 4'd0, 4'd0};
    setEdges(1, s, d);
    applyStimulus();
    drainRows(5, -1, -1, 7'd1);
    checkOutput("stall_row0", gotRow[0], 16'h0002);

    s = '{4'd1, 4'd0, 4'd0, 4'd0};
    d = '{4'd2, 4'd0, 4'd0, 4'd0};
    setEdges(1, s, d);
    applyStimulus();
    drainRows(0, 3, -1, 7'd1);
    checkOutput("emit_pulse_row7", gotRow[7], 16'h0000);
    checkOutput("emit_pulse_row8", gotRow[8], 16'h0000);

    s = '{4'd2, 4'd4, 4'd6, 4'd0};
    d = '{4'd3, 4'd5, 4'd7, 4'd0};
    setEdges(3, s, d);
    applyStimulus();
    drainRows(0, -1, 6, 7'd3);
    @(negedge clk);
    checkIdle("abort_reset");
    rst_n = 1'b1;
    sbQ.delete();
    repeat (4) begin
      @(negedge clk);
      checkIdle("abort_quiet");
    end

    s = '{4'd0, 4'd0, 4'd0, 4'd0};
    d = '{4'd1, 4'd0, 4'd0, 4'd0};
    setEdges(1, s, d);
    applyStimulus();
    drainRows(0, -1, -1, 7'd1);
    checkOutput("post_abort_row1", gotRow[1], 16'h0001);
    checkOutput("post_abort_row2", gotRow[2], 16'h0000);
    checkOutput("post_abort_row6", gotRow[6], 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
